firmware_loader: RTL and testbench

- Write-side counterpart of the firmware/vector ROM.
- Accepts a framed byte stream (from the UART receiver or debug bridge) and issues byte writes into firmware memory and the 6-byte vector memory.
- Holds the 6502 in reset while loading; flags success or failure when the frame ends.
- Sits between the serial RX front end and the firmware ROM/RAM write port.

---
 rtl/firmware_loader_pkg.sv | 29 ++
 rtl/firmware_loader_if.sv | 32 +++
 rtl/firmware_loader_timeout.sv | 28 ++
 rtl/firmware_loader.sv | 143 ++++++++++++++
 tb/tb_firmware_loader.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/firmware_loader_pkg.sv
// rtl/firmware_loader_pkg.sv - mapache64 shared types plus the firmware loader additions
package mapache64;

  typedef logic [7:0] data_t;

  localparam int FirmwareAddressWidth = 10;
  typedef logic [FirmwareAddressWidth-1:0] firmware_address_t;
  localparam int FirmwareSize = 1 << FirmwareAddressWidth;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    FW,
    VEC,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  localparam int VectorCount = 6;
  localparam logic [2:0] VectorAddressOffset = 3'h2;

  // True while a frame is being received (MAGIC seen, checksum not yet judged).
  function automatic logic loader_in_frame(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == FW) || (s == VEC) || (s == CSUM);
  endfunction

endpackage

// File: rtl/firmware_loader_if.sv
// rtl/firmware_loader_if.sv - byte stream input and memory write port of the firmware loader
interface firmware_loader_if;
  import mapache64::*;

  data_t             rx_data_i;
  logic              rx_valid_i;
  logic              rx_ready_o;
  logic              wr_en_o;
  firmware_address_t wr_address_o;
  data_t             wr_data_o;
  logic              wr_firmware_o;
  logic              wr_vectors_o;
  logic              cpu_hold_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  // Host side: serial front end feeding bytes and observing the loader.
  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, wr_en_o, wr_address_o, wr_data_o, wr_firmware_o,
    input  wr_vectors_o, cpu_hold_o, busy_o, done_o, error_o
  );

  // Loader side.
  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, wr_en_o, wr_address_o, wr_data_o, wr_firmware_o,
    output wr_vectors_o, cpu_hold_o, busy_o, done_o, error_o
  );

endinterface

// File: rtl/firmware_loader_timeout.sv
// rtl/firmware_loader_timeout.sv - inter-byte watchdog, built only with FIRMWARE_LOADER_TIMEOUT_EN
`ifdef FIRMWARE_LOADER_TIMEOUT_EN
module firmware_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  logic [31:0] count;

  // Expiry is flagged on the TIMEOUT_CYCLES-th idle cycle so the FSM errors on that edge.
  assign expired = enable && (count == 32'(TIMEOUT_CYCLES - 1));

  // Count idle cycles; any accepted byte or leaving the frame restarts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || kick || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/firmware_loader.sv
// rtl/firmware_loader.sv - framed byte stream to firmware/vector memory writer (option: FIRMWARE_LOADER_TIMEOUT_EN)
module firmware_loader
  import mapache64::*;
#(
  parameter data_t MAGIC = 8'hA5
`ifdef FIRMWARE_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  firmware_loader_if.slave  bus
);

  loader_state_t     state;
  logic [15:0]       len;
  firmware_address_t idx;
  data_t             sum;
  logic              accept;
  logic              timeout_expired;
  logic [15:0]       len_full;
  logic [2:0]        vec_addr;

  // The loader never back-pressures, so every valid byte is taken.
  assign accept   = bus.rx_valid_i;
  assign len_full = {bus.rx_data_i, len[7:0]};
  assign vec_addr = idx[2:0] + VectorAddressOffset;

`ifdef FIRMWARE_LOADER_TIMEOUT_EN
  firmware_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .kick    (accept),
    .enable  (loader_in_frame(state)),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // Frame parser: advances on accepted bytes, issues one-cycle registered writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      len               <= '0;
      idx               <= '0;
      sum               <= '0;
      bus.rx_ready_o    <= 1'b1;
      bus.wr_en_o       <= 1'b0;
      bus.wr_firmware_o <= 1'b0;
      bus.wr_vectors_o  <= 1'b0;
      bus.wr_address_o  <= '0;
      bus.wr_data_o     <= '0;
      bus.busy_o        <= 1'b0;
      bus.done_o        <= 1'b0;
      bus.error_o       <= 1'b0;
      bus.cpu_hold_o    <= 1'b0;
    end else begin
      bus.rx_ready_o    <= 1'b1;
      bus.wr_en_o       <= 1'b0;
      bus.wr_firmware_o <= 1'b0;
      bus.wr_vectors_o  <= 1'b0;

      if (loader_in_frame(state) && !accept && timeout_expired) begin
        state          <= ERROR;
        bus.error_o    <= 1'b1;
        bus.busy_o     <= 1'b0;
        bus.cpu_hold_o <= 1'b1;
      end else if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (bus.rx_data_i == MAGIC) begin
              state          <= LEN_LO;
              sum            <= '0;
              bus.done_o     <= 1'b0;
              bus.error_o    <= 1'b0;
              bus.busy_o     <= 1'b1;
              bus.cpu_hold_o <= 1'b1;
            end
          end
          LEN_LO: begin
            len[7:0] <= bus.rx_data_i;
            sum      <= sum + bus.rx_data_i;
            state    <= LEN_HI;
          end
          LEN_HI: begin
            len[15:8] <= bus.rx_data_i;
            sum       <= sum + bus.rx_data_i;
            if (len_full == 16'd0 || len_full > 16'(FirmwareSize)) begin
              state       <= ERROR;
              bus.error_o <= 1'b1;
              bus.busy_o  <= 1'b0;
            end else begin
              state <= FW;
              idx   <= '0;
            end
          end
          FW: begin
            sum               <= sum + bus.rx_data_i;
            bus.wr_en_o       <= 1'b1;
            bus.wr_firmware_o <= 1'b1;
            bus.wr_address_o  <= idx;
            bus.wr_data_o     <= bus.rx_data_i;
            if (16'(idx) == len - 16'd1) begin
              state <= VEC;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          VEC: begin
            sum              <= sum + bus.rx_data_i;
            bus.wr_en_o      <= 1'b1;
            bus.wr_vectors_o <= 1'b1;
            bus.wr_address_o <= firmware_address_t'(vec_addr);
            bus.wr_data_o    <= bus.rx_data_i;
            if (idx == firmware_address_t'(VectorCount - 1)) begin
              state <= CSUM;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          CSUM: begin
            bus.busy_o <= 1'b0;
            if (data_t'(sum + bus.rx_data_i) == 8'h00) begin
              state          <= DONE;
              bus.done_o     <= 1'b1;
              bus.cpu_hold_o <= 1'b0;
            end else begin
              state       <= ERROR;
              bus.error_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_firmware_loader.sv
// tb/tb_firmware_loader.sv - directed self-checking bench for firmware_loader
module tb_firmware_loader;
  import mapache64::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   sel_leak;
  logic [19:0] wq[$];
  logic [7:0]  tx[$];

  firmware_loader_if bus ();

  firmware_loader #(
    .MAGIC (8'hA5)
`ifdef FIRMWARE_LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every write as {vectors, firmware, address, data}; flag select lines without a strobe.
  always @(negedge clk) begin
    if (bus.wr_en_o) begin
      wq.push_back({bus.wr_vectors_o, bus.wr_firmware_o, 10'(bus.wr_address_o), bus.wr_data_o});
    end else if (bus.wr_firmware_o || bus.wr_vectors_o) begin
      sel_leak++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_tx();
    foreach (tx[i]) send(tx[i]);
  endtask

  task automatic load_good(input logic [7:0] csum);
    tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, csum};
  endtask

  // {busy, done, error, cpu_hold}
  function automatic logic [3:0] status();
    return {bus.busy_o, bus.done_o, bus.error_o, bus.cpu_hold_o};
  endfunction

  task automatic check_good_writes(input string tag);
    logic [19:0] exp_w[8];
    exp_w = '{{2'b01, 10'd0, 8'h11}, {2'b01, 10'd1, 8'h22},
              {2'b10, 10'd2, 8'h00}, {2'b10, 10'd3, 8'h80},
              {2'b10, 10'd4, 8'h00}, {2'b10, 10'd5, 8'h80},
              {2'b10, 10'd6, 8'h00}, {2'b10, 10'd7, 8'h80}};
    check({tag, "_count"}, wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wq.size()) check($sformatf("%s_w%0d", tag, i), wq[i], exp_w[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {bus.rx_ready_o, bus.wr_en_o, bus.wr_firmware_o, bus.wr_vectors_o, status()}, 8'b1000_0000);
    check({tag, "_addr"}, bus.wr_address_o, 0);
    check({tag, "_data"}, bus.wr_data_o, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sel_leak = 0;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Good frame.
    wq.delete();
    load_good(8'h4B);
    send(tx[0]);
    check("magic_status", status(), 4'b1001);
    tx.pop_front();
    send_tx();
    check("good_status", status(), 4'b0100);
    check_good_writes("good");

    // Bad checksum, then recovery with the good frame.
    wq.delete();
    load_good(8'h4C);
    send_tx();
    check("bad_status", status(), 4'b0011);
    check_good_writes("bad");
    wq.delete();
    load_good(8'h4B);
    send_tx();
    check("reload_status", status(), 4'b0100);
    check_good_writes("reload");

    // LEN = 0.
    wq.delete();
    tx = '{8'hA5, 8'h00, 8'h00};
    send_tx();
    check("len0_status", status(), 4'b0011);
    check("len0_writes", wq.size(), 0);

    // LEN = FirmwareSize + 1.
    tx = '{8'hA5, 8'h01, 8'h04};
    send_tx();
    check("lenover_status", status(), 4'b0011);
    check("lenover_writes", wq.size(), 0);

    // LEN = FirmwareSize, data i[7:0], zero vectors; byte sum is 0x04 so CSUM is 0xFC.
    wq.delete();
    tx = '{8'hA5, 8'h00, 8'h04};
    for (int i = 0; i < 1024; i++) tx.push_back(8'(i));
    for (int i = 0; i < 6; i++) tx.push_back(8'h00);
    tx.push_back(8'hFC);
    send_tx();
    check("lenmax_status", status(), 4'b0100);
    check("lenmax_count", wq.size(), 1030);
    if (wq.size() == 1030) begin
      check("lenmax_last_fw", wq[1023], {2'b01, 10'd1023, 8'hFF});
      check("lenmax_first_vec", wq[1024], {2'b10, 10'd2, 8'h00});
    end

    // Non-MAGIC bytes in IDLE are ignored.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
    tx = '{8'h00, 8'hFF, 8'h5A};
    send_tx();
    check("ignore_status", status(), 4'b0000);
    check("ignore_writes", wq.size(), 0);
    send(8'hA5);
    check("ignore_magic", status(), 4'b1001);

    // Reset after 5 bytes of a good frame.
    tx = '{8'h02, 8'h00, 8'h11, 8'h22};
    send_tx();
    check("mid_status", status(), 4'b1001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    wq.delete();
    load_good(8'h4B);
    send_tx();
    check("after_rst_status", status(), 4'b0100);
    check_good_writes("after_rst");

`ifdef FIRMWARE_LOADER_TIMEOUT_EN
    // Stall after MAGIC: still waiting after 15 idle cycles, ERROR on the 16th.
    send(8'hA5);
    repeat (15) @(posedge clk);
    #1;
    check("to_pre", status(), 4'b1001);
    @(posedge clk);
    #1;
    check("to_expired", status(), 4'b0011);
    // A byte landing on the 16th cycle beats the timeout.
    send(8'hA5);
    repeat (15) @(posedge clk);
    #1;
    send(8'h02);
    check("to_byte_wins", status(), 4'b1001);
    repeat (4) @(posedge clk);
    #1;
    check("to_restarted", status(), 4'b1001);
`endif

    check("select_without_strobe", sel_leak, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
